namuru_frontend_if: RTL and testbench

Upstream stage of gps_channel_correlator. It captures the 2-bit sign/mag IF stream from the GPS RF front-end, which arrives on its own sample clock, and resynchronises it into the correlator_clk domain. It emits one-cycle sample strobes with optional decimation, flags a stalled front-end, and provides a firmware snapshot buffer of raw samples for spectrum and debug use.

---
 rtl/namuru_fe_pkg.sv | 12 +
 rtl/namuru_fe_sync.sv | 28 ++
 rtl/namuru_frontend_if.sv | 145 ++++++++++++++
 tb/tb_namuru_frontend_if.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/namuru_fe_pkg.sv
// namuru_fe_pkg: shared types and constants for the Namuru front-end interface.
package namuru_fe_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} snap_state_t;
  localparam int SAMPLE_BITS = 2;
  localparam int WORD_SAMPLES = 16;
  localparam logic [9:0] LFSR_SEED = 10'h3FF;
  localparam logic [9:0] LFSR_TAPS = 10'h204;
  // x^10 + x^3 + 1, shifting towards the MSB
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/namuru_fe_sync.sv
// namuru_fe_sync: 2-FF resynchroniser for fe_clk/sign/mag with fe_clk rising-edge detect.
module namuru_fe_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_fe_clk,
  input  logic i_fe_sign,
  input  logic i_fe_mag,
  output logic o_edge,
  output logic o_sign,
  output logic o_mag
);
  logic [2:0] r_s1, r_s2;
  logic r_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_prev <= 1'b0;
    end else begin
      r_s1 <= {i_fe_clk, i_fe_sign, i_fe_mag};
      r_s2 <= r_s1;
      r_prev <= r_s2[2];
    end
  end
  assign o_edge = r_s2[2] & ~r_prev;
  assign o_sign = r_s2[1];
  assign o_mag = r_s2[0];
endmodule

// File: rtl/namuru_frontend_if.sv
// namuru_frontend_if: resynchronised, decimated IF sample stream with stall flag and snapshot buffer.
// Optional NAMURU_FE_TESTGEN_EN builds an LFSR test pattern source selected by test_mode.
module namuru_frontend_if import namuru_fe_pkg::*; #(
  parameter int SNAP_AW = 6,
  parameter int STALL_CYCLES = 1024
) (
  input  logic correlator_clk,
  input  logic correlator_rst,
  input  logic fe_clk,
  input  logic fe_sign,
  input  logic fe_mag,
  input  logic [3:0] decim,
  input  logic test_mode,
  output logic sign,
  output logic mag,
  output logic sample_enable,
  output logic fe_stall,
  input  logic snap_arm,
  input  logic snap_rd,
  output logic snap_busy,
  output logic snap_done,
  output logic [31:0] snap_data,
  output logic [SNAP_AW:0] snap_level
);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam int PW = $clog2(WORD_SAMPLES);
  localparam logic [SNAP_AW:0] WORDS = {1'b1, {SNAP_AW{1'b0}}};
  logic w_sync_edge, w_sync_sign, w_sync_mag, w_edge, w_sign, w_mag, w_sat;
  logic r_sign, r_mag, r_se;
  logic [3:0] r_dcnt;
  logic [SW-1:0] r_stall;
  snap_state_t r_state, w_next;
  logic [31-SAMPLE_BITS:0] r_pack;
  logic [31:0] w_pack, r_data;
  logic [PW-1:0] r_pcnt;
  logic [SNAP_AW-1:0] r_wptr, r_rptr;
  logic [SNAP_AW:0] r_level;
  logic [31:0] r_ram [2**SNAP_AW];
  logic w_word, w_arm, w_pop;
  namuru_fe_sync u_sync (
    .clk(correlator_clk), .rst(correlator_rst),
    .i_fe_clk(fe_clk), .i_fe_sign(fe_sign), .i_fe_mag(fe_mag),
    .o_edge(w_sync_edge), .o_sign(w_sync_sign), .o_mag(w_sync_mag)
  );
`ifdef NAMURU_FE_TESTGEN_EN
  logic [9:0] r_lfsr;
  logic [1:0] r_tdiv;
  // Held at seed while the front-end is selected so each test run starts identically
  always_ff @(posedge correlator_clk) begin
    if (correlator_rst || !test_mode) begin
      r_lfsr <= LFSR_SEED;
      r_tdiv <= '0;
    end else begin
      r_tdiv <= r_tdiv + 2'd1;
      if (r_tdiv == 2'd3) r_lfsr <= lfsr_next(r_lfsr);
    end
  end
  assign w_edge = test_mode ? (r_tdiv == 2'd3) : w_sync_edge;
  assign w_sign = test_mode ? r_lfsr[9] : w_sync_sign;
  assign w_mag = test_mode ? r_lfsr[8] : w_sync_mag;
  assign fe_stall = w_sat & ~test_mode;
`else
  logic w_unused;
  assign w_unused = test_mode;
  assign w_edge = w_sync_edge;
  assign w_sign = w_sync_sign;
  assign w_mag = w_sync_mag;
  assign fe_stall = w_sat;
`endif
  assign w_sat = r_stall == SW'(STALL_CYCLES);
  always_ff @(posedge correlator_clk) begin
    if (correlator_rst) begin
      r_sign <= 1'b0;
      r_mag <= 1'b0;
      r_se <= 1'b0;
      r_dcnt <= '0;
      r_stall <= '0;
    end else begin
      r_se <= 1'b0;
      if (w_edge) begin
        r_stall <= '0;
        if (r_dcnt == '0) begin
          r_se <= 1'b1;
          r_sign <= w_sign;
          r_mag <= w_mag;
          r_dcnt <= decim;
        end else r_dcnt <= r_dcnt - 4'd1;
      end else if (!w_sat) r_stall <= r_stall + SW'(1);
    end
  end
  assign w_pack = {r_pack, r_sign, r_mag};
  assign w_word = r_state == FILL && r_se && r_pcnt == PW'(WORD_SAMPLES - 1);
  assign w_arm = snap_arm && r_state != FILL;
  assign w_pop = snap_rd && r_state == DONE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (snap_arm ? FILL : IDLE)
           : (r_state == FILL) ? ((w_word && r_wptr == '1) ? DONE : FILL)
           : snap_arm ? FILL
           : (snap_rd && r_level == (SNAP_AW+1)'(1)) ? IDLE : DONE;
  end
  always_ff @(posedge correlator_clk) begin
    if (correlator_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge correlator_clk) begin
    if (correlator_rst) begin
      r_pack <= '0;
      r_pcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_data <= '0;
    end else if (w_arm) begin
      r_pack <= '0;
      r_pcnt <= '0;
      r_wptr <= '0;
      r_level <= '0;
    end else if (r_state == FILL && r_se) begin
      r_pack <= w_pack[31-SAMPLE_BITS:0];
      r_pcnt <= r_pcnt + PW'(1);
      if (w_word) begin
        r_wptr <= r_wptr + SNAP_AW'(1);
        if (r_wptr == '1) begin
          r_rptr <= '0;
          r_level <= WORDS;
        end
      end
    end else if (w_pop) begin
      r_data <= r_ram[r_rptr];
      r_rptr <= r_rptr + SNAP_AW'(1);
      r_level <= r_level - (SNAP_AW+1)'(1);
    end
  end
  always_ff @(posedge correlator_clk) begin
    if (w_word) r_ram[r_wptr] <= w_pack;
  end
  assign sign = r_sign;
  assign mag = r_mag;
  assign sample_enable = r_se;
  assign snap_busy = r_state == FILL;
  assign snap_done = r_state == DONE;
  assign snap_data = r_data;
  assign snap_level = r_level;
endmodule

// File: tb/tb_namuru_frontend_if.sv
// tb_namuru_frontend_if: self-checking bench; front-end pins driven by a divided clock generator,
// strobes checked against an edge-level sample model, snapshot words rebuilt from captured samples.
module tb_namuru_frontend_if;
  logic correlator_clk, correlator_rst, fe_clk, fe_sign, fe_mag, test_mode, snap_arm, snap_rd;
  logic [3:0] decim;
  logic sign, mag, sample_enable, fe_stall, snap_busy, snap_done;
  logic [31:0] snap_data;
  logic [6:0] snap_level;
  typedef struct {int t; logic s; logic m;} smp_t;
  typedef struct {int decim; int mode; int half; int n; int spacing;} row_t;
  smp_t mq[$];
  logic [1:0] cap[$];
  row_t rows[6];
  int cyc = 0, n_checks = 0, n_fail = 0, m_skip = 0, half = 4, mode = 0, ph = 0;
  bit fe_run = 0, chk_en = 0, tg = 0;
  logic [9:0] ml;

  namuru_frontend_if dut (
    .correlator_clk(correlator_clk), .correlator_rst(correlator_rst),
    .fe_clk(fe_clk), .fe_sign(fe_sign), .fe_mag(fe_mag),
    .decim(decim), .test_mode(test_mode),
    .sign(sign), .mag(mag), .sample_enable(sample_enable), .fe_stall(fe_stall),
    .snap_arm(snap_arm), .snap_rd(snap_rd), .snap_busy(snap_busy), .snap_done(snap_done),
    .snap_data(snap_data), .snap_level(snap_level)
  );

  initial begin
    correlator_clk = 0;
    forever #5 correlator_clk = ~correlator_clk;
  end
  initial forever begin
    @(posedge correlator_clk);
    cyc++;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Front-end model: every pin rising edge is a sample; forwarded ones appear 3 cycles later
  task automatic model_rise();
    if (m_skip == 0) begin
      mq.push_back('{cyc + 3, fe_sign, fe_mag});
      m_skip = int'(decim);
    end else m_skip--;
  endtask

  initial begin
    fe_clk = 0; fe_sign = 0; fe_mag = 0;
    forever begin
      @(negedge correlator_clk);
      if (fe_run || fe_clk) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          fe_clk = ~fe_clk;
          if (fe_clk) model_rise();
          else if (mode == 0) begin fe_sign = ~fe_sign; fe_mag = 0; end
          else if (mode == 1) begin fe_sign = 1; fe_mag = 0; end
          else {fe_sign, fe_mag} = 2'($urandom);
        end
      end
    end
  end

  initial begin
    logic es, em;
    smp_t e;
    forever begin
      @(negedge correlator_clk);
      if (chk_en && sample_enable) begin
        if (tg) begin
          es = ml[9]; em = ml[8];
          ml = {ml[8:0], ml[9] ^ ml[2]};
        end else if (mq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_strobe: sample_enable=1 required 0 (cycle %0d)", cyc);
          es = sign; em = mag;
        end else begin
          e = mq.pop_front();
          chk("strobe_time", 64'(cyc), 64'(e.t));
          es = e.s; em = e.m;
        end
        chk("sign_mag", {sign, mag}, {es, em});
        if (snap_busy) cap.push_back({es, em});
      end else if (chk_en && !tg && mq.size() != 0 && mq[0].t < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL missed_strobe: sample_enable=0 required 1 at cycle %0d", mq[0].t);
        void'(mq.pop_front());
      end
    end
  end

  task automatic wait_se(output int t);
    int k = 0;
    do begin
      @(negedge correlator_clk);
      k++;
    end while (!sample_enable && k < 600);
    if (!sample_enable) begin
      n_checks++; n_fail++;
      $display("FAIL wait_strobe: none within %0d cycles", k);
    end
    t = cyc;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!snap_done && k < 9000) begin
      @(negedge correlator_clk);
      k++;
    end
    chk("snap_done", snap_done, 1);
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w = '0;
    for (int j = 0; j < 16; j++) w = {w[29:0], cap[16 * i + j]};
    return w;
  endfunction

  task automatic pop_chk(input logic [31:0] ew, input int lvl);
    snap_rd = 1;
    @(negedge correlator_clk);
    snap_rd = 0;
    chk("snap_data", snap_data, ew);
    chk("snap_level", snap_level, 64'(lvl));
  endtask

  initial begin
    int t, t0;
    rows[0] = '{0, 0, 4, 6, 8};
    rows[1] = '{3, 0, 4, 3, 32};
    rows[2] = '{1, 0, 4, 4, 16};
    rows[3] = '{0, 2, 2, 8, 4};
    rows[4] = '{2, 2, 2, 4, 12};
    rows[5] = '{0, 0, 4, 3, 8};
    correlator_rst = 1; decim = 0; test_mode = 0; snap_arm = 0; snap_rd = 0;
    repeat (3) @(negedge correlator_clk);
    chk("reset_outputs", {sign, mag, sample_enable, fe_stall, snap_busy, snap_done, snap_data, snap_level}, 0);
    correlator_rst = 0; chk_en = 1; fe_run = 1;
    for (int i = 0; i < 6; i++) begin
      wait_se(t);
      decim = 4'(rows[i].decim); mode = rows[i].mode; half = rows[i].half;
      wait_se(t);
      t0 = t;
      for (int j = 0; j < rows[i].n; j++) begin
        wait_se(t);
        chk("strobe_spacing", 64'(t - t0), 64'(rows[i].spacing));
        t0 = t;
      end
    end
    // snapshot of a constant 2'b10 stream, with a stray arm while filling
    mode = 1; half = 2;
    repeat (3) wait_se(t);
    cap.delete();
    snap_arm = 1;
    @(negedge correlator_clk);
    snap_arm = 0;
    chk("busy_after_arm", {snap_busy, snap_done}, 2'b10);
    repeat (100) @(negedge correlator_clk);
    snap_arm = 1;
    @(negedge correlator_clk);
    snap_arm = 0;
    chk("arm_in_fill", snap_busy, 1);
    wait_done();
    chk("full_level", snap_level, 64);
    chk("fill_samples", 64'(cap.size()), 1024);
    for (int i = 0; i < 64; i++) pop_chk(32'hAAAAAAAA, 63 - i);
    chk("idle_after_drain", {snap_busy, snap_done}, 0);
    pop_chk(32'hAAAAAAAA, 0);
    chk("rd_in_idle", {snap_busy, snap_done}, 0);
    // random stream, partial drain, then re-arm together with a read
    mode = 2;
    cap.delete();
    snap_arm = 1;
    @(negedge correlator_clk);
    snap_arm = 0;
    wait_done();
    for (int i = 0; i < 10; i++) pop_chk(exp_word(i), 63 - i);
    cap.delete();
    snap_arm = 1; snap_rd = 1;
    @(negedge correlator_clk);
    snap_arm = 0; snap_rd = 0;
    chk("rearm_wins", {snap_busy, snap_done, snap_level}, {2'b10, 7'd0});
    wait_done();
    chk("refill_level", snap_level, 64);
    for (int i = 0; i < 64; i++) pop_chk(exp_word(i), 63 - i);
    // stall: 1024 cycles after the last strobe, cleared with the first new strobe
    mode = 0; half = 4; decim = 0;
    repeat (3) wait_se(t);
    fe_run = 0;
    repeat (1023) @(negedge correlator_clk);
    chk("stall_early", fe_stall, 0);
    @(negedge correlator_clk);
    chk("stall_exact", fe_stall, 1);
    repeat (50) @(negedge correlator_clk);
    chk("stall_held", {fe_stall, sample_enable}, 2'b10);
    fe_run = 1;
    wait_se(t);
    chk("stall_cleared", fe_stall, 0);
    wait_se(t0);
    chk("resume_spacing", 64'(t0 - t), 8);
    // reset while filling discards the snapshot
    fe_run = 0;
    repeat (20) @(negedge correlator_clk);
    snap_arm = 1;
    @(negedge correlator_clk);
    snap_arm = 0;
    chk("fill_no_fe", snap_busy, 1);
    correlator_rst = 1; m_skip = 0;
    @(negedge correlator_clk);
    correlator_rst = 0;
    chk("reset_in_fill", {snap_busy, snap_done, snap_level}, 0);
`ifdef NAMURU_FE_TESTGEN_EN
    tg = 1; ml = 10'h3FF; test_mode = 1;
    wait_se(t);
    chk("tg_first", {sign, mag}, 2'b11);
    wait_se(t0);
    chk("tg_spacing", 64'(t0 - t), 4);
    chk("tg_no_stall", fe_stall, 0);
    cap.delete();
    snap_arm = 1;
    @(negedge correlator_clk);
    snap_arm = 0;
    wait_done();
    for (int i = 0; i < 64; i++) pop_chk(exp_word(i), 63 - i);
`endif
    repeat (5) @(negedge correlator_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
